// File: rtl/servo_pwm_pkg.sv
// Shared constants and types for the servo PWM bank.
// The default widths assume a 50 MHz clock and a 20 ms servo frame.
package servo_pwm_pkg;

    localparam int CLK_HZ         = 50_000_000;
    localparam int PERIOD_20MS    = 1_000_000;
    localparam int TICKS_PER_MS   = 50_000;

    localparam int DEF_CNT_W      = 20;
    localparam int DEF_MIN_DUTY   = 25_000;   // 0.5 ms
    localparam int DEF_MAX_DUTY   = 125_000;  // 2.5 ms
    localparam int DEF_RESET_DUTY = 75_000;   // 1.5 ms, servo neutral

    // Direction of the per-period width change toward the target.
    typedef enum logic [1:0] {
        SLEW_HOLD = 2'b00,
        SLEW_UP   = 2'b01,
        SLEW_DOWN = 2'b10
    } slew_dir_e;

endpackage

// File: rtl/servo_pwm_chan.sv
// One servo channel: clamped target, active width with optional slew limit,
// enable latched at the period boundary, and a registered width compare.
module servo_pwm_chan
    import servo_pwm_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int MIN_DUTY   = DEF_MIN_DUTY,
    parameter int MAX_DUTY   = DEF_MAX_DUTY,
    parameter int RESET_DUTY = DEF_RESET_DUTY,
    parameter int STEP       = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] count,
    input  logic             boundary,
    input  logic [CNT_W-1:0] duty_in,
    input  logic             load,
    input  logic             en,
    output logic             pwm
);

    // One extra bit so compares and add/subtract can never wrap.
    localparam int EW = CNT_W + 1;

    localparam logic [EW-1:0]    MIN_E   = EW'(MIN_DUTY);
    localparam logic [EW-1:0]    MAX_E   = EW'(MAX_DUTY);
    localparam logic [EW-1:0]    STEP_E  = EW'(STEP);
    localparam logic [CNT_W-1:0] MIN_V   = CNT_W'(MIN_DUTY);
    localparam logic [CNT_W-1:0] MAX_V   = CNT_W'(MAX_DUTY);
    localparam logic [CNT_W-1:0] RESET_V = CNT_W'(RESET_DUTY);

    logic [EW-1:0]    duty_ext_s;
    logic [CNT_W-1:0] target_next_s;
    logic [EW-1:0]    target_ext_s;
    logic [EW-1:0]    active_ext_s;
    logic [EW-1:0]    diff_s;
    logic [EW-1:0]    delta_s;
    logic [EW-1:0]    up_ext_s;
    logic [EW-1:0]    dn_ext_s;
    slew_dir_e        slew_dir_s;
    logic [CNT_W-1:0] active_next_s;

    logic [CNT_W-1:0] target_r;
    logic [CNT_W-1:0] active_r;
    logic             en_act_r;
    logic             pwm_r;

    // Clamp the requested width into the servo-safe window (unsigned).
    always_comb begin
        duty_ext_s    = {1'b0, duty_in};
        target_next_s = duty_in;
        if (duty_ext_s < MIN_E) begin
            target_next_s = MIN_V;
        end else if (duty_ext_s > MAX_E) begin
            target_next_s = MAX_V;
        end else begin
            target_next_s = duty_in;
        end
    end

    // Distance and direction from the active width to the target.
    always_comb begin
        target_ext_s = {1'b0, target_r};
        active_ext_s = {1'b0, active_r};
        slew_dir_s   = SLEW_HOLD;
        diff_s       = {EW{1'b0}};
        if (target_ext_s > active_ext_s) begin
            slew_dir_s = SLEW_UP;
            diff_s     = target_ext_s - active_ext_s;
        end else if (target_ext_s < active_ext_s) begin
            slew_dir_s = SLEW_DOWN;
            diff_s     = active_ext_s - target_ext_s;
        end else begin
            slew_dir_s = SLEW_HOLD;
            diff_s     = {EW{1'b0}};
        end
    end

    // Width to take at the next boundary: the target directly, or one
    // bounded step toward it that cannot overshoot.
    always_comb begin
        delta_s       = (diff_s > STEP_E) ? STEP_E : diff_s;
        up_ext_s      = active_ext_s + delta_s;
        dn_ext_s      = active_ext_s - delta_s;
        active_next_s = active_r;
        if (STEP == 0) begin
            active_next_s = target_r;
        end else begin
            case (slew_dir_s)
                // An out-of-range carry/borrow is impossible by construction;
                // fall back to the (always in-range) target if it ever appears.
                SLEW_UP:   active_next_s = up_ext_s[CNT_W] ? target_r : up_ext_s[CNT_W-1:0];
                SLEW_DOWN: active_next_s = dn_ext_s[CNT_W] ? target_r : dn_ext_s[CNT_W-1:0];
                SLEW_HOLD: active_next_s = active_r;
                default:   active_next_s = target_r;
            endcase
        end
    end

    // Target register: the last load in a period wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target_r <= RESET_V;
        end else if (load) begin
            target_r <= target_next_s;
        end
    end

    // Active width and enable change only at the boundary, so every period
    // carries one whole pulse or none.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_r <= RESET_V;
            en_act_r <= 1'b0;
        end else if (boundary) begin
            active_r <= active_next_s;
            en_act_r <= en;
        end
    end

    // Registered pulse output: high for counts 0..active-1 of the period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_r <= 1'b0;
        end else begin
            pwm_r <= en_act_r && (count < active_r);
        end
    end

    assign pwm = pwm_r;

endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM bank: one shared period counter, CH channels.
module servo_pwm_bank
    import servo_pwm_pkg::*;
#(
    parameter int CH         = 4,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int PERIOD     = PERIOD_20MS,
    parameter int MIN_DUTY   = DEF_MIN_DUTY,
    parameter int MAX_DUTY   = DEF_MAX_DUTY,
    parameter int RESET_DUTY = DEF_RESET_DUTY,
    parameter int STEP       = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH*CNT_W-1:0] duty_in,
    input  logic [CH-1:0]       load,
    input  logic [CH-1:0]       en,
    output logic [CH-1:0]       pwm,
    output logic                period_start
);

    localparam logic [CNT_W-1:0] LAST_V = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);

    // Widths must nest inside the period and the period must fit the counter.
    if (!((MIN_DUTY <= RESET_DUTY) && (RESET_DUTY <= MAX_DUTY) &&
          (MAX_DUTY <= PERIOD) && (PERIOD >= 2) &&
          (PERIOD <= (1 << CNT_W)) && (MAX_DUTY < (1 << CNT_W)))) begin : g_cfg_err
        $error("servo_pwm_bank: need MIN_DUTY <= RESET_DUTY <= MAX_DUTY <= PERIOD within CNT_W bits");
    end

    logic [CNT_W-1:0] count_r;
    logic             boundary_s;
    logic             period_start_r;
    logic [CH-1:0]    pwm_s;

    assign boundary_s = (count_r == LAST_V);

    // Shared period counter, 0..PERIOD-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (boundary_s) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_r + ONE_V;
        end
    end

    // Period-start flag, registered so it is high exactly while count is 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_start_r <= 1'b0;
        end else begin
            period_start_r <= boundary_s;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_chan
        servo_pwm_chan #(
            .CNT_W      (CNT_W),
            .MIN_DUTY   (MIN_DUTY),
            .MAX_DUTY   (MAX_DUTY),
            .RESET_DUTY (RESET_DUTY),
            .STEP       (STEP)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .count    (count_r),
            .boundary (boundary_s),
            .duty_in  (duty_in[i*CNT_W +: CNT_W]),
            .load     (load[i]),
            .en       (en[i]),
            .pwm      (pwm_s[i])
        );
    end

    assign pwm          = pwm_s;
    assign period_start = period_start_r;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Scoreboard bench for servo_pwm_bank: two instances (no slew, STEP=2)
// share stimulus; a period-level model predicts each period's pulse width.
module tb_servo_pwm_bank;

    localparam int CH    = 2;
    localparam int CNT_W = 8;
    localparam int P     = 20;
    localparam int MIN_D = 2;
    localparam int MAX_D = 10;
    localparam int RST_D = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                rst_q = 1'b0;
    logic [CH*CNT_W-1:0] duty_in = '0;
    logic [CH-1:0]       load = '0;
    logic [CH-1:0]       en = '0;
    logic [CH-1:0]       pw [2];
    logic                ps [2];

    int n_vec = 0;
    int n_err = 0;

    // Expected widths per period, 8 bits each: [(dut*2+ch)*8 +: 8].
    bit [31:0] exp_q [$];

    // Reference model state, indexed [dut][ch].
    int tgt [2][2];
    int act [2][2];
    bit ena [2][2];
    int tcount = 0;

    // Monitor state.
    int acc [2][2];
    int spacing = 0;
    bit ps_seen = 1'b0;

    always #5 clk = ~clk;

    servo_pwm_bank #(.CH(CH), .CNT_W(CNT_W), .PERIOD(P), .MIN_DUTY(MIN_D),
                     .MAX_DUTY(MAX_D), .RESET_DUTY(RST_D), .STEP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .duty_in(duty_in), .load(load), .en(en),
        .pwm(pw[0]), .period_start(ps[0]));

    servo_pwm_bank #(.CH(CH), .CNT_W(CNT_W), .PERIOD(P), .MIN_DUTY(MIN_D),
                     .MAX_DUTY(MAX_D), .RESET_DUTY(RST_D), .STEP(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .duty_in(duty_in), .load(load), .en(en),
        .pwm(pw[1]), .period_start(ps[1]));

    always @(posedge clk) rst_q <= rst_n;

    function automatic int clampv(input int v);
        if (v < MIN_D) return MIN_D;
        if (v > MAX_D) return MAX_D;
        return v;
    endfunction

    function automatic int slew(input int a, input int t, input int stp);
        if (stp == 0) return t;
        if (t > a) return (t - a > stp) ? a + stp : t;
        if (t < a) return (a - t > stp) ? a - stp : t;
        return a;
    endfunction

    // One clock: advance the model with the inputs the DUT samples at this edge.
    task automatic tick();
        bit        bnd;
        bit [31:0] e;
        @(posedge clk);
        if (!rst_n) begin
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < CH; c++) begin
                    tgt[d][c] = RST_D;
                    act[d][c] = RST_D;
                    ena[d][c] = 1'b0;
                end
            tcount = 0;
            exp_q.delete();
            exp_q.push_back(32'd0);
        end else begin
            bnd = (tcount == P - 1);
            if (bnd) begin
                for (int d = 0; d < 2; d++)
                    for (int c = 0; c < CH; c++) begin
                        act[d][c] = slew(act[d][c], tgt[d][c], (d == 0) ? 0 : 2);
                        ena[d][c] = en[c];
                    end
            end
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < CH; c++)
                    if (load[c]) tgt[d][c] = clampv(int'(duty_in[c*CNT_W +: CNT_W]));
            if (bnd) begin
                e = 32'd0;
                for (int d = 0; d < 2; d++)
                    for (int c = 0; c < CH; c++)
                        e[(d*2+c)*8 +: 8] = ena[d][c] ? 8'(act[d][c]) : 8'd0;
                exp_q.push_back(e);
            end
            tcount = bnd ? 0 : tcount + 1;
        end
        #1;
    endtask

    task automatic run_to(input int k);
        int guard;
        guard = 0;
        while (tcount != k && guard < 3 * P) begin
            tick();
            guard++;
        end
        if (tcount != k) begin
            n_vec++;
            n_err++;
            $display("FAIL run_to: count %0d, wanted %0d", tcount, k);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: accumulate high cycles per period, compare at each period_start.
    always @(negedge clk) begin
        bit [31:0] e;
        int        w;
        if (!rst_q) begin
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if (pw[d] !== '0 || ps[d] !== 1'b0) begin
                    n_err++;
                    $display("FAIL reset_state dut%0d: pwm=%b period_start=%b, need 0", d, pw[d], ps[d]);
                end
                for (int c = 0; c < CH; c++) acc[d][c] = 0;
            end
            ps_seen = 1'b0;
            spacing = 0;
        end else begin
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < CH; c++)
                    if (pw[d][c] === 1'b1) acc[d][c]++;
            spacing++;
            n_vec++;
            if (ps[0] !== ps[1]) begin
                n_err++;
                $display("FAIL ps_match: dut0=%b dut1=%b", ps[0], ps[1]);
            end
            if (ps[0] === 1'b1) begin
                if (ps_seen) begin
                    n_vec++;
                    if (spacing != P) begin
                        n_err++;
                        $display("FAIL ps_spacing: got %0d clocks, need %0d", spacing, P);
                    end
                end
                ps_seen = 1'b1;
                spacing = 0;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL scoreboard: period ended with no expectation queued");
                end else begin
                    e = exp_q.pop_front();
                    for (int d = 0; d < 2; d++)
                        for (int c = 0; c < CH; c++) begin
                            w = int'(e[(d*2+c)*8 +: 8]);
                            n_vec++;
                            if (acc[d][c] != w) begin
                                n_err++;
                                $display("FAIL width dut%0d ch%0d: got %0d high, need %0d", d, c, acc[d][c], w);
                            end
                        end
                end
                for (int d = 0; d < 2; d++)
                    for (int c = 0; c < CH; c++) acc[d][c] = 0;
            end
        end
    end

    initial begin
        // Reset, then enable both channels with no load.
        rst_n = 1'b0;
        ticks(3);
        rst_n = 1'b1;
        en = 2'b11;
        ticks(3 * P);

        // Clamp: ch0 below minimum, ch1 above maximum.
        run_to(5);
        duty_in = {8'd15, 8'd0};
        load = 2'b11;
        tick();
        load = 2'b00;
        ticks(3 * P);

        // Load exactly at the boundary cycle.
        run_to(P - 1);
        duty_in = {8'd0, 8'd8};
        load = 2'b01;
        tick();
        load = 2'b00;
        ticks(3 * P);

        // Settle at 5, then slew ch1 toward 10.
        duty_in = {8'd5, 8'd5};
        load = 2'b11;
        tick();
        load = 2'b00;
        ticks(5 * P);
        duty_in = {8'd10, 8'd5};
        load = 2'b10;
        tick();
        load = 2'b00;
        ticks(5 * P);

        // Drop enable mid-pulse, then re-enable mid-period.
        run_to(3);
        en = 2'b10;
        ticks(2 * P);
        run_to(7);
        en = 2'b11;
        ticks(2 * P);

        // Reset in the middle of a pulse.
        run_to(2);
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        ticks(3 * P);

        // Randomized loads, enables and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            load = 2'b00;
            if ($urandom_range(0, 7) == 0) begin
                load = 2'($urandom_range(1, 3));
                if ($urandom_range(0, 3) == 0)
                    duty_in = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
                else
                    duty_in = {8'($urandom_range(0, 14)), 8'($urandom_range(0, 14))};
            end
            if ($urandom_range(0, 31) == 0) en = en ^ 2'($urandom_range(1, 2));
            rst_n = ($urandom_range(0, 999) != 0);
            tick();
        end
        rst_n = 1'b1;
        load = 2'b00;
        ticks(3 * P);
        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() > 1) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, need at most 1", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
